// File: rtl/udm_bus_arbiter_pkg.sv
// Shared definitions for the UDM bus arbiter slice.
// Bus field widths, master ID constants and the arbiter FSM encoding.
package udm_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Master IDs double as the 1-bit tags held in the response ID FIFO.
  localparam logic M_UDM = 1'b0;
  localparam logic M_CPU = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/udm_bus_arbiter_if.sv
// Simple req/ack/resp bus used by the UDM debug controller.
// master modport: drives req/we/addr/be/wdata, receives ack/resp/rdata.
// slave modport : the mirror image.
interface udm_bus_if;
  import udm_pkg::*;

  logic              req;
  logic              ack;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic              resp;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, resp, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, resp, rdata);

endinterface

// File: rtl/udm_id_fifo.sv
// In-order FIFO of 1-bit master IDs for outstanding reads.
// Ports: clk_i/reset_i (sync, active high), push/din, pop/dout, full, empty.
// Push and pop may happen in the same cycle. Callers never push when full
// or pop when empty.
module udm_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  // One extra pointer bit tells full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/udm_bus_arbiter.sv
// Two-master, one-slave arbiter for the UDM req/ack/resp bus.
// m0 = UART debug master, m1 = processor data port, s = shared slave bus.
// Ports: clk_i, reset_i (sync, active high), m0/m1 (slave side of each
// master bus), s (master side toward the slave), err_o (sticky: read
// response arrived with no outstanding read).
// One master is granted per address phase; accepted reads tag the ID FIFO
// so each read response is routed back to its issuer in order.
module udm_bus_arbiter
  import udm_pkg::*;
#(
  parameter bit RR_MODE    = 1'b1,
  parameter int RESP_DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      reset_i,
  udm_bus_if.slave  m0,
  udm_bus_if.slave  m1,
  udm_bus_if.master s,
  output logic      err_o
);

  arb_state_e state;
  logic       gnt_id;
  logic       last_id;

  logic              g_req, g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [BE_W-1:0]   g_be;
  logic [DATA_W-1:0] g_wdata;
  logic              granted, accept, push, pop, win;
  logic              head, full, empty;

  udm_id_fifo #(.DEPTH(RESP_DEPTH)) u_id_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push   (push),
    .din    (gnt_id),
    .pop    (pop),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    g_req   = (gnt_id == M_CPU) ? m1.req   : m0.req;
    g_we    = (gnt_id == M_CPU) ? m1.we    : m0.we;
    g_addr  = (gnt_id == M_CPU) ? m1.addr  : m0.addr;
    g_be    = (gnt_id == M_CPU) ? m1.be    : m0.be;
    g_wdata = (gnt_id == M_CPU) ? m1.wdata : m0.wdata;
    granted = (state == ST_GRANT);

    // A read is held off while the ID FIFO is full; writes never stall.
    s.req   = granted & g_req & ~(~g_we & full);
    s.we    = granted & g_we;
    s.addr  = granted ? g_addr  : '0;
    s.be    = granted ? g_be    : '0;
    s.wdata = granted ? g_wdata : '0;

    accept  = s.ack & s.req;
    push    = accept & ~g_we;
    m0.ack  = accept & (gnt_id == M_UDM);
    m1.ack  = accept & (gnt_id == M_CPU);

    // Responses with nothing outstanding are dropped (and flagged below).
    pop      = s.resp & ~empty;
    m0.resp  = pop & (head == M_UDM);
    m1.resp  = pop & (head == M_CPU);
    m0.rdata = m0.resp ? s.rdata : '0;
    m1.rdata = m1.resp ? s.rdata : '0;

    // Contention goes to whoever did not win last; otherwise the lone requester.
    if (RR_MODE && m0.req && m1.req) win = ~last_id;
    else                             win = ~m0.req;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      gnt_id  <= M_UDM;
      last_id <= M_CPU;
      err_o   <= 1'b0;
    end else begin
      if (s.resp & empty) err_o <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (m0.req | m1.req) begin
            gnt_id <= win;
            state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (accept) begin
            last_id <= gnt_id;
            state   <= ST_IDLE;
          end else if (!g_req) begin
            // Master withdrew its request: abandon the grant.
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udm_bus_arbiter.sv
module tb_udm_bus_arbiter;
  import udm_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  udm_bus_if m0_if();
  udm_bus_if m1_if();
  udm_bus_if s_if();
  udm_bus_if f0_if();
  udm_bus_if f1_if();
  udm_bus_if fs_if();
  logic err, ferr;

  logic        mreq[2];
  logic        mwe[2];
  logic [31:0] maddr[2];
  logic [3:0]  mbe[2];
  logic [31:0] mwdata[2];
  logic        sack, sresp;
  logic [31:0] srdata;
  logic        freq[2];
  logic        fack;

  assign m0_if.req = mreq[0];  assign m0_if.we = mwe[0];  assign m0_if.addr = maddr[0];
  assign m0_if.be  = mbe[0];   assign m0_if.wdata = mwdata[0];
  assign m1_if.req = mreq[1];  assign m1_if.we = mwe[1];  assign m1_if.addr = maddr[1];
  assign m1_if.be  = mbe[1];   assign m1_if.wdata = mwdata[1];
  assign s_if.ack  = sack;     assign s_if.resp = sresp;  assign s_if.rdata = srdata;

  assign f0_if.req = freq[0];  assign f0_if.we = 1'b1;  assign f0_if.addr = 32'h40;
  assign f0_if.be  = 4'hF;     assign f0_if.wdata = 32'h0;
  assign f1_if.req = freq[1];  assign f1_if.we = 1'b1;  assign f1_if.addr = 32'h80;
  assign f1_if.be  = 4'hF;     assign f1_if.wdata = 32'h0;
  assign fs_if.ack = fack;     assign fs_if.resp = 1'b0; assign fs_if.rdata = 32'h0;

  udm_bus_arbiter #(.RR_MODE(1'b1), .RESP_DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(rst), .m0(m0_if), .m1(m1_if), .s(s_if), .err_o(err));

  udm_bus_arbiter #(.RR_MODE(1'b0), .RESP_DEPTH(DEPTH)) dut_fix (
    .clk_i(clk), .reset_i(rst), .m0(f0_if), .m1(f1_if), .s(fs_if), .err_o(ferr));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Grant owner (-1 = none), last winner, queue of outstanding read owners.
  int  mg = -1;
  bit  mlast = 1'b1;
  bit  mq[$];
  bit  merr = 1'b0;
  bit  model_on = 1'b0;

  bit          e_sreq, e_swe, rd;
  logic [31:0] e_saddr, e_swdata;
  logic [3:0]  e_sbe;
  bit          e_ack[2], e_resp[2];
  logic [31:0] e_rd[2];

  always @(negedge clk) begin
    e_sreq = 0; e_swe = 0; e_saddr = 0; e_sbe = 0; e_swdata = 0;
    e_ack[0] = 0; e_ack[1] = 0; e_resp[0] = 0; e_resp[1] = 0;
    e_rd[0] = 0; e_rd[1] = 0;
    if (mg >= 0) begin
      rd       = !mwe[mg];
      e_sreq   = mreq[mg] && !(rd && mq.size() == DEPTH);
      e_swe    = mwe[mg];
      e_saddr  = maddr[mg];
      e_sbe    = mbe[mg];
      e_swdata = mwdata[mg];
      e_ack[mg] = sack && e_sreq;
    end
    if (sresp && mq.size() > 0) begin
      e_resp[mq[0]] = 1;
      e_rd[mq[0]]   = srdata;
    end
    if (model_on) begin
      chk("s_req", s_if.req, e_sreq);
      chk("s_we", s_if.we, e_swe);
      chk("s_addr", s_if.addr, e_saddr);
      chk("s_be", s_if.be, e_sbe);
      chk("s_wdata", s_if.wdata, e_swdata);
      chk("m0_ack", m0_if.ack, e_ack[0]);
      chk("m1_ack", m1_if.ack, e_ack[1]);
      chk("m0_resp", m0_if.resp, e_resp[0]);
      chk("m1_resp", m1_if.resp, e_resp[1]);
      chk("m0_rdata", m0_if.rdata, e_rd[0]);
      chk("m1_rdata", m1_if.rdata, e_rd[1]);
      chk("err", err, merr);
    end
    if (rst) begin
      mg = -1; mlast = 1'b1; mq.delete(); merr = 1'b0;
    end else begin
      if (sresp) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else merr = 1'b1;
      end
      if (mg < 0) begin
        if (mreq[0] && mreq[1]) mg = mlast ? 0 : 1;
        else if (mreq[0])       mg = 0;
        else if (mreq[1])       mg = 1;
      end else if (e_ack[mg]) begin
        if (!mwe[mg]) mq.push_back(mg == 1);
        mlast = (mg == 1);
        mg = -1;
      end else if (!mreq[mg]) begin
        mg = -1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic new_txn(input int k);
    mreq[k]   = 1'b1;
    mwe[k]    = 1'($urandom_range(0, 1));
    maddr[k]  = $urandom;
    mbe[k]    = 4'($urandom_range(0, 15));
    mwdata[k] = $urandom;
  endtask

  initial begin
    bit a[2];
    for (int k = 0; k < 2; k++) begin
      mreq[k] = 0; mwe[k] = 0; maddr[k] = 0; mbe[k] = 0; mwdata[k] = 0; freq[k] = 0;
    end
    sack = 0; sresp = 0; srdata = 0; fack = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0; model_on = 1'b1;

    // reset state
    smp(); chk("rst_sreq", s_if.req, 0); chk("rst_err", err, 0); chk("rst_m0ack", m0_if.ack, 0);

    // single m0 read at 0x100, response 3 cycles after accept
    nxt(); mreq[0] = 1; mwe[0] = 0; maddr[0] = 32'h100; mbe[0] = 4'hF;
    smp(); chk("idle_no_sreq", s_if.req, 0);
    nxt(); sack = 1;
    smp(); chk("rd_sreq", s_if.req, 1); chk("rd_addr", s_if.addr, 32'h100);
    chk("rd_m0ack", m0_if.ack, 1); chk("rd_m1ack", m1_if.ack, 0);
    nxt(); mreq[0] = 0; sack = 0;
    nxt(); nxt();
    nxt(); sresp = 1; srdata = 32'hDEADBEEF;
    smp(); chk("rd_m0resp", m0_if.resp, 1); chk("rd_m0rdata", m0_if.rdata, 32'hDEADBEEF);
    chk("rd_m1resp", m1_if.resp, 0);
    nxt(); sresp = 0; srdata = 0;
    smp(); chk("rd_resp_oneshot", m0_if.resp, 0);

    // m0 read then m1 read, responses come back in issue order
    nxt(); mreq[0] = 1; maddr[0] = 32'h200;
    nxt(); sack = 1;
    smp(); chk("ord_m0ack", m0_if.ack, 1);
    nxt(); mreq[0] = 0; sack = 0; mreq[1] = 1; mwe[1] = 0; maddr[1] = 32'h300; mbe[1] = 4'hF;
    nxt(); sack = 1;
    smp(); chk("ord_m1ack", m1_if.ack, 1); chk("ord_m1addr", s_if.addr, 32'h300);
    nxt(); mreq[1] = 0; sack = 0; sresp = 1; srdata = 32'h11111111;
    smp(); chk("ord_r0_m0", m0_if.resp, 1); chk("ord_r0_data", m0_if.rdata, 32'h11111111);
    chk("ord_r0_m1", m1_if.resp, 0);
    nxt(); srdata = 32'h22222222;
    smp(); chk("ord_r1_m1", m1_if.resp, 1); chk("ord_r1_data", m1_if.rdata, 32'h22222222);
    chk("ord_r1_m0", m0_if.resp, 0);
    nxt(); sresp = 0; srdata = 0;

    // m1 write: exact fields, same-cycle ack, nothing queued
    nxt(); mreq[1] = 1; mwe[1] = 1; maddr[1] = 32'h20; mwdata[1] = 32'hCAFE0000; mbe[1] = 4'hF;
    nxt(); sack = 1;
    smp(); chk("wr_we", s_if.we, 1); chk("wr_addr", s_if.addr, 32'h20);
    chk("wr_wdata", s_if.wdata, 32'hCAFE0000); chk("wr_be", s_if.be, 4'hF);
    chk("wr_m1ack", m1_if.ack, 1); chk("wr_m0ack", m0_if.ack, 0);
    nxt(); mreq[1] = 0; sack = 0;
    // FIFO still empty after the write: a response is an error
    nxt(); sresp = 1; srdata = 32'h55;
    smp(); chk("err_no_m0resp", m0_if.resp, 0); chk("err_no_m1resp", m1_if.resp, 0);
    chk("err_not_yet", err, 0);
    nxt(); sresp = 0; srdata = 0;
    smp(); chk("err_set", err, 1);
    nxt(); nxt();
    smp(); chk("err_sticky", err, 1);

    // fill the ID FIFO: fifth read stalls until a pop
    nxt(); mreq[0] = 1; mwe[0] = 0; maddr[0] = 32'h400; sack = 1;
    for (int i = 0; i < 4; i++) begin
      smp(); chk("fill_idle", s_if.req, 0);
      nxt();
      smp(); chk("fill_ack", m0_if.ack, 1);
      nxt(); maddr[0] = maddr[0] + 32'h4;
    end
    nxt();
    smp(); chk("full_stall", s_if.req, 0); chk("full_noack", m0_if.ack, 0);
    nxt();
    smp(); chk("full_stall2", s_if.req, 0);
    nxt(); sresp = 1; srdata = 32'hA0;
    smp(); chk("full_pop_sreq", s_if.req, 0); chk("full_pop_resp", m0_if.resp, 1);
    nxt(); sresp = 0;
    smp(); chk("fifth_issued", s_if.req, 1); chk("fifth_ack", m0_if.ack, 1);
    nxt(); mreq[0] = 0; sack = 0; sresp = 1;
    for (int i = 0; i < 4; i++) begin
      srdata = 32'hB0 + 32'(i);
      smp(); chk("drain_resp", m0_if.resp, 1);
      nxt();
    end
    sresp = 0; srdata = 0;

    // reset while granted
    mreq[0] = 1; maddr[0] = 32'h500;
    nxt();
    smp(); chk("rg_sreq", s_if.req, 1);
    nxt(); rst = 1;
    nxt(); rst = 0; mreq[0] = 0;
    smp(); chk("rg_sreq_cleared", s_if.req, 0); chk("rg_err_cleared", err, 0);

    // round robin: both masters write continuously, m0 goes first after reset
    nxt(); mreq[0] = 1; mwe[0] = 1; maddr[0] = 32'h10; mreq[1] = 1; mwe[1] = 1; maddr[1] = 32'h14;
    sack = 1;
    for (int i = 0; i < 4; i++) begin
      smp();
      nxt();
      smp(); chk("rr_m0", m0_if.ack, (i % 2 == 0)); chk("rr_m1", m1_if.ack, (i % 2 == 1));
      nxt();
    end
    mreq[0] = 0; mreq[1] = 0; sack = 0;

    // fixed priority instance: m1 only wins while m0 is quiet
    freq[0] = 1; freq[1] = 1; fack = 1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      smp(); chk("fix_m0", f0_if.ack, 1); chk("fix_m1", f1_if.ack, 0);
      nxt();
    end
    freq[0] = 0;
    nxt();
    smp(); chk("fix_m1_alone", f1_if.ack, 1);
    nxt(); freq[1] = 0; fack = 0;

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      smp(); a[0] = m0_if.ack; a[1] = m1_if.ack;
      nxt();
      rst = (n == 1000);
      for (int k = 0; k < 2; k++) begin
        if (mreq[k]) begin
          if (a[k]) begin
            mreq[k] = 0;
            if ($urandom_range(0, 1) == 0) new_txn(k);
          end else if ($urandom_range(0, 39) == 0) begin
            mreq[k] = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_txn(k);
        end
      end
      sack   = ($urandom_range(0, 2) != 0);
      sresp  = ($urandom_range(0, 3) == 0);
      srdata = $urandom;
    end
    rst = 0;
    smp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/udm_bus_arbiter.md
# udm_bus_arbiter

Two-master, one-slave arbiter for the simple req/ack/resp bus driven by the UDM debug controller. Lets the UART debug master (m0) and a processor data port (m1) share one slave bus (memory/peripheral interconnect). Grants one master per address phase and tracks outstanding reads in an in-order ID FIFO so each read response returns to the master that issued it.

## Interface
- RR_MODE, 1: 1 = round-robin between m0/m1; 0 = fixed priority, m0 (debug) wins.
- RESP_DEPTH, 4: max outstanding reads (power of two, ≥2).
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- mX_req_i  in  1  master X request (X = 0, 1); held until mX_ack_o.
- mX_ack_o  out  1  address phase accepted.
- mX_we_i  in  1  1 = write.
- mX_addr_bi  in  32  byte address.
- mX_be_bi  in  4  byte enables.
- mX_wdata_bi  in  32  write data.
- mX_resp_o  out  1  read data valid, one cycle.
- mX_rdata_bo  out  32  read data; 0 when mX_resp_o = 0.
- s_req_o, s_we_o  out  1  slave request / write.
- s_addr_bo  out  32; s_be_bo  out  4; s_wdata_bo  out  32  granted master's fields; 0 when no grant.
- s_ack_i  in  1  slave accepted.
- s_resp_i  in  1  slave read data valid.
- s_rdata_bi  in  32  slave read data.
- err_o  out  1  sticky: s_resp_i seen with empty ID FIFO.

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if any mX_req_i, pick winner, register gnt_id, go GRANT. No slave request in IDLE.
- Winner: RR_MODE=0 → m0 if requesting, else m1. RR_MODE=1 → if both request, master ≠ last_id wins; last_id resets to 1 (m0 first).
- GRANT: s_* fields = granted master's fields. s_req_o = req of granted master AND NOT (read AND FIFO full). mX_ack_o = s_ack_i AND s_req_o for granted X only.
- On accepted read (s_ack_i & s_req_o & !we): push gnt_id into FIFO. Writes push nothing.
- On accept: last_id <= gnt_id, go IDLE.
- Granted master drops req without ack (protocol violation): return to IDLE next cycle, no push.
- Response: s_resp_i pops FIFO head; routes resp and s_rdata_bi to head master. Empty FIFO: drop, set err_o (clears only on reset).
- Push and pop in same cycle: both happen, count unchanged; full + pop + push legal only if the read was issued (gated by full as above, so it is not).
- Reset: state IDLE, FIFO empty, last_id=1, err_o=0; all outputs 0. Outstanding responses after reset are dropped and flag err_o.

## Timing
- Arbitration latency: req sampled in IDLE at cycle t → s_req_o at t+1.
- Address phase: s_*, mX_ack_o combinational from gnt_id and inputs; s_ack_i → mX_ack_o zero-cycle.
- One IDLE bubble between consecutive transactions; back-to-back throughput one transfer per 2 cycles minimum.
- Response path combinational: s_resp_i at t → mX_resp_o at t, responses in issue order.
- FIFO full: read stalls in GRANT with req held; released the cycle after a pop.

## Structure
- Shared package udm_pkg: bus field widths (ADDR 32, DATA 32, BE 4), master ID constants M_UDM=0, M_CPU=1, state encodings.
- Sub-module udm_id_fifo: synchronous FIFO of 1-bit IDs, depth RESP_DEPTH, push/pop/full/empty, simultaneous push/pop.

## Test plan
- m0 read addr 0x100 alone; slave acks next cycle, resp 3 cycles later with 0xDEADBEEF → m0_resp_o one cycle, m0_rdata_bo=0xDEADBEEF, m1_resp_o=0.
- Both request every cycle, RR_MODE=1 → grants alternate m0,m1,m0,m1; RR_MODE=0 → m1 granted only when m0_req_i low.
- m0 read, then m1 read, responses 0x11111111 and 0x22222222 in order → routed to m0 then m1.
- RESP_DEPTH=4, five reads with no responses → fifth stalls s_req_o=0; one resp → fifth issued within 2 cycles.
- Write by m1 (addr 0x20, data 0xCAFE0000, be 0xF) → slave sees exact fields, m1_ack_o same cycle as s_ack_i, FIFO count unchanged.
- s_resp_i with empty FIFO → err_o=1 sticky, no mX_resp_o; reset_i in GRANT → next cycle s_req_o=0, err_o=0, FIFO empty.
